// File: rtl/codec_rjm_slave_port.sv
// Codec-side right-justified audio port: oversamples the master's BCLK/LRCK/DAC lines,
// deserializes stereo DAC samples and serializes stereo ADC samples back.
module codec_rjm_slave_port #(
  parameter int DATA_W     = 24,
  parameter int HALF_BCLKS = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              bclk_i,
  input  logic              lrck_i,
  input  logic              dac_dat_i,
  input  logic [DATA_W-1:0] adc_left_i,
  input  logic [DATA_W-1:0] adc_right_i,
  output logic              adc_dat_o,
  output logic [DATA_W-1:0] dac_left_o,
  output logic [DATA_W-1:0] dac_right_o,
  output logic              dac_valid_o,
  output logic              frame_err_o
);

  localparam logic [6:0] HALF_CNT = 7'(HALF_BCLKS);
  localparam logic [6:0] CNT_MAX  = 7'd127;

  logic                  bclk_p0, bclk_p1, bclk_p2;
  logic                  lrck_p0, lrck_p1, lrck_p2;
  logic                  dat_p0, dat_p1, dat_p2;
  logic                  bclk_rise_p3, bclk_fall_p3, lr_edge_p3;
  logic [DATA_W-1:0]     rx_sh;
  logic [DATA_W-1:0]     rx_cur;
  logic [HALF_BCLKS-1:0] tx_sh;
  logic [6:0]            bit_cnt;
  logic                  armed;

  // Stages p0..p2: two-flop synchronizers plus one history flop per line
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bclk_p0 <= 1'b0; bclk_p1 <= 1'b0; bclk_p2 <= 1'b0;
      lrck_p0 <= 1'b0; lrck_p1 <= 1'b0; lrck_p2 <= 1'b0;
      dat_p0  <= 1'b0; dat_p1  <= 1'b0; dat_p2  <= 1'b0;
    end else begin
      bclk_p0 <= bclk_i;    bclk_p1 <= bclk_p0; bclk_p2 <= bclk_p1;
      lrck_p0 <= lrck_i;    lrck_p1 <= lrck_p0; lrck_p2 <= lrck_p1;
      dat_p0  <= dac_dat_i; dat_p1  <= dat_p0;  dat_p2  <= dat_p1;
    end
  end

  // Stage p3: registered edge pulses; dat_p2 and lrck_p2 are aligned with them
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bclk_rise_p3 <= 1'b0;
      bclk_fall_p3 <= 1'b0;
      lr_edge_p3   <= 1'b0;
    end else begin
      bclk_rise_p3 <= bclk_p1 & ~bclk_p2;
      bclk_fall_p3 <= ~bclk_p1 & bclk_p2;
      lr_edge_p3   <= lrck_p1 ^ lrck_p2;
    end
  end

  // A coincident rise and LR edge captures the already-shifted word
  always_comb begin
    rx_cur = rx_sh;
    if (bclk_rise_p3) rx_cur = {rx_sh[DATA_W-2:0], dat_p2};
  end

  // Stage p4: shift registers, half-frame capture and frame check
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_sh       <= '0;
      tx_sh       <= '0;
      bit_cnt     <= '0;
      armed       <= 1'b0;
      dac_left_o  <= '0;
      dac_right_o <= '0;
      dac_valid_o <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      dac_valid_o <= 1'b0;
      if (!en_i) begin
        armed <= 1'b0;
      end else begin
        if (bclk_rise_p3) begin
          rx_sh <= rx_cur;
          if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 7'd1;
        end
        if (lr_edge_p3) begin
          if (lrck_p2) begin
            dac_right_o <= rx_cur;
            dac_valid_o <= 1'b1;
            tx_sh       <= HALF_BCLKS'(adc_left_i);
          end else begin
            dac_left_o  <= rx_cur;
            tx_sh       <= HALF_BCLKS'(adc_right_i);
          end
          if (armed && (bit_cnt != HALF_CNT)) frame_err_o <= 1'b1;
          bit_cnt <= '0;
          armed   <= 1'b1;
        end else if (bclk_fall_p3) begin
          tx_sh <= {tx_sh[HALF_BCLKS-2:0], 1'b0};
        end
      end
    end
  end

  assign adc_dat_o = en_i & tx_sh[HALF_BCLKS-1];

endmodule

// File: tb/tb_codec_rjm_slave_port.sv
// Directed bench: a bit-banged RJM master drives a 32-BCLK instance and a 24-BCLK instance.
module tb_codec_rjm_slave_port;

  logic        clk_i = 1'b0;
  logic        rst_i, en_i;
  logic [1:0]  bclk, lrck, dac;
  logic [23:0] adc_l, adc_r;
  logic [1:0]  adc_w;
  logic [23:0] left_a, right_a, left_b, right_b;
  logic        valid_a, valid_b, err_a, err_b;
  int          vcnt_a = 0, vcnt_b = 0, wide = 0;
  logic        prev_a = 1'b0, prev_b = 1'b0;
  int          n_chk = 0, n_err = 0;
  logic [63:0] cap;
  int          v0;

  always #5 clk_i = ~clk_i;

  codec_rjm_slave_port #(.DATA_W(24), .HALF_BCLKS(32)) u_a (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .bclk_i(bclk[0]), .lrck_i(lrck[0]),
    .dac_dat_i(dac[0]), .adc_left_i(adc_l), .adc_right_i(adc_r), .adc_dat_o(adc_w[0]),
    .dac_left_o(left_a), .dac_right_o(right_a), .dac_valid_o(valid_a), .frame_err_o(err_a));

  codec_rjm_slave_port #(.DATA_W(24), .HALF_BCLKS(24)) u_b (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .bclk_i(bclk[1]), .lrck_i(lrck[1]),
    .dac_dat_i(dac[1]), .adc_left_i(adc_l), .adc_right_i(adc_r), .adc_dat_o(adc_w[1]),
    .dac_left_o(left_b), .dac_right_o(right_b), .dac_valid_o(valid_b), .frame_err_o(err_b));

  always @(posedge clk_i) begin
    if (valid_a) vcnt_a++;
    if (valid_b) vcnt_b++;
    if ((valid_a && prev_a) || (valid_b && prev_b)) wide++;
    prev_a = valid_a;
    prev_b = valid_b;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One half-frame: LRCK changes with the first falling BCLK, pad bits are ones,
  // ADC bits are captured just before each rising BCLK.
  task automatic send_half(input int sel, input logic lr, input int n,
                           input logic [23:0] smp, output logic [63:0] c);
    c = '0;
    for (int i = 0; i < n; i++) begin
      bclk[sel] = 1'b0;
      if (i == 0) lrck[sel] = lr;
      dac[sel] = (i < n - 24) ? 1'b1 : smp[n-1-i];
      repeat (4) @(negedge clk_i);
      c = {c[62:0], adc_w[sel]};
      bclk[sel] = 1'b1;
      repeat (4) @(negedge clk_i);
    end
  endtask

  task automatic pulse_reset;
    @(negedge clk_i) rst_i = 1'b1;
    @(negedge clk_i) rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b1; bclk = 2'b11; lrck = 2'b00; dac = 2'b00;
    adc_l = 24'h800001; adc_r = 24'h7FFFFE;
    repeat (3) @(negedge clk_i);
    chk("rst_left", left_a, 0);
    chk("rst_right", right_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_adc", adc_w[0], 0);
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);

    // Loopback and transmit, 32-BCLK halves with 8 pad bits
    send_half(0, 1'b1, 32, 24'hA5A5A5, cap);
    chk("tx_left", cap[31:0], {8'h00, 24'h800001});
    v0 = vcnt_a;
    send_half(0, 1'b0, 32, 24'h5A5A5A, cap);
    chk("tx_right", cap[31:0], {8'h00, 24'h7FFFFE});
    chk("rx_left", left_a, 24'hA5A5A5);
    send_half(0, 1'b1, 32, 24'hA5A5A5, cap);
    chk("rx_right", right_a, 24'h5A5A5A);
    chk("valid_per_frame", vcnt_a - v0, 1);
    chk("err_clean", err_a, 0);

    // Reset partway through a half
    send_half(0, 1'b0, 10, 24'h000000, cap);
    pulse_reset();
    chk("midrst_left", left_a, 0);
    chk("midrst_right", right_a, 0);
    chk("midrst_valid", valid_a, 0);
    chk("midrst_err", err_a, 0);
    chk("midrst_adc", adc_w[0], 0);
    send_half(0, 1'b1, 32, 24'h123456, cap);
    send_half(0, 1'b0, 32, 24'hFEDCBA, cap);
    chk("post_rst_left", left_a, 24'h123456);
    send_half(0, 1'b1, 32, 24'h123456, cap);
    chk("post_rst_right", right_a, 24'hFEDCBA);
    chk("post_rst_err", err_a, 0);

    // Disabled for three LRCK periods
    en_i = 1'b0;
    v0 = vcnt_a;
    for (int k = 0; k < 3; k++) begin
      send_half(0, 1'b0, 32, 24'h111111, cap);
      chk("dis_adc_r", cap[31:0], 0);
      send_half(0, 1'b1, 32, 24'h222222, cap);
      chk("dis_adc_l", cap[31:0], 0);
    end
    chk("dis_hold_left", left_a, 24'h123456);
    chk("dis_hold_right", right_a, 24'hFEDCBA);
    chk("dis_no_valid", vcnt_a - v0, 0);
    en_i = 1'b1;
    send_half(0, 1'b0, 32, 24'hABCDEF, cap);
    send_half(0, 1'b1, 32, 24'h135791, cap);
    chk("reen_right", right_a, 24'hABCDEF);
    chk("reen_tx_left", cap[31:0], {8'h00, 24'h800001});
    send_half(0, 1'b0, 32, 24'h2468AC, cap);
    chk("reen_left", left_a, 24'h135791);
    chk("reen_err", err_a, 0);

    // Short half-frame sets the sticky error
    send_half(0, 1'b1, 32, 24'hA5A5A5, cap);
    send_half(0, 1'b0, 31, 24'h5A5A5A, cap);
    chk("short_before_edge", err_a, 0);
    send_half(0, 1'b1, 32, 24'hA5A5A5, cap);
    chk("short_err_set", err_a, 1);
    chk("short_right", right_a, 24'h5A5A5A);
    send_half(0, 1'b0, 32, 24'h5A5A5A, cap);
    send_half(0, 1'b1, 32, 24'hA5A5A5, cap);
    chk("err_sticky", err_a, 1);
    pulse_reset();
    chk("err_cleared", err_a, 0);

    // No-pad instance: HALF_BCLKS equals DATA_W
    send_half(1, 1'b1, 24, 24'hC3A50F, cap);
    chk("b_tx_left", cap[23:0], 24'h800001);
    v0 = vcnt_b;
    send_half(1, 1'b0, 24, 24'h3C5AF0, cap);
    chk("b_tx_right", cap[23:0], 24'h7FFFFE);
    chk("b_rx_left", left_b, 24'hC3A50F);
    send_half(1, 1'b1, 24, 24'hC3A50F, cap);
    chk("b_rx_right", right_b, 24'h3C5AF0);
    chk("b_valid", vcnt_b - v0, 1);
    chk("b_err", err_b, 0);
    chk("valid_width", wide, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
